// File: rtl/fpadd_arbiter_pkg.sv
// fpadd_arbiter_pkg
//   Shared definitions for the fpadd arbiter: FP32 field widths, the quiet-NaN
//   value returned on a watchdog abort, and the arbiter FSM state encoding.
//   No ports; imported by fpadd_arbiter and fpadd_arbiter_rr_pick.
package fpadd_arbiter_pkg;

    localparam int FP_SIGN_W = 1;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MANT_W;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fpadd_arbiter_rr_pick.sv
// fpadd_arbiter_rr_pick
//   Combinational round-robin picker. Scans requesters starting one past the
//   previous winner and returns the first one holding a request.
// Ports
//   req      in  N_REQ  request levels
//   rr_last  in  IDX_W  index of the previous winner (lowest priority now)
//   win      out N_REQ  one-hot winner, zero when no request
//   idx      out IDX_W  winner index, zero when no request
//   any      out 1      at least one request present
module fpadd_arbiter_rr_pick
    import fpadd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_last,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        cand  = '0;
        win   = '0;
        idx   = '0;
        any   = |req;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rr_last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter
//   Shares one fpadd single-precision adder between N_REQ requesters:
//   round-robin arbitration, operand capture, start/done sequencing with a
//   watchdog, and result return to the granted requester.
// Ports
//   clk        in   1            clock, rising edge
//   reset      in   1            async, active-low
//   req        in   N_REQ        per-requester request level
//   req_a      in   32*N_REQ     operand A, requester i at [32*i +: 32]
//   req_b      in   32*N_REQ     operand B, same packing
//   gnt        out  N_REQ        one-hot pulse: operands captured
//   rsp_valid  out  N_REQ        one-hot pulse: result for that requester
//   rsp_sum    out  32           result, qualified by rsp_valid
//   rsp_err    out  1            watchdog abort, qualified by rsp_valid
//   busy       out  1            high outside IDLE
//   fpu_a      out  32           to fpadd a, stable ISSUE..RESP
//   fpu_b      out  32           to fpadd b, stable ISSUE..RESP
//   fpu_start  out  1            to fpadd start, single-cycle pulse
//   fpu_sum    in   32           from fpadd sum
//   fpu_done   in   1            from fpadd done (sticky until next start)
//
// State | Meaning
// IDLE  | no operation; arbitrate and capture winner operands
// ISSUE | pulse gnt to owner and fpu_start; clear watchdog
// WAIT  | wait for fpu_done or watchdog expiry
// RESP  | pulse rsp_valid to owner with sum / error
module fpadd_arbiter
    import fpadd_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_sum,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [FP_W-1:0]       fpu_a,
    output logic [FP_W-1:0]       fpu_b,
    output logic                  fpu_start,
    input  logic [FP_W-1:0]       fpu_sum,
    input  logic                  fpu_done
);

    localparam int                IDX_W     = $clog2(N_REQ);
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic [N_REQ-1:0]   owner_oh;
    logic               win_any;
    logic [WDOG_W-1:0]  wdog;
    logic               done_seen;
    logic               wdog_expired;

    fpadd_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .rr_last (rr_last),
        .win     (win_oh),
        .idx     (win_idx),
        .any     (win_any)
    );

    // wdog is zero only in the first WAIT cycle; fpadd clears done on the
    // start edge, so done seen there may still be the previous op's.
    assign done_seen    = fpu_done && (wdog != '0);
    assign wdog_expired = (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (win_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_seen || wdog_expired) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        gnt             = (state == ST_ISSUE) ? owner_oh : '0;
        rsp_valid       = (state == ST_RESP)  ? owner_oh : '0;
        fpu_start       = (state == ST_ISSUE);
        busy            = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner   <= '0;
            rr_last <= IDX_W'(N_REQ - 1);
            fpu_a   <= '0;
            fpu_b   <= '0;
            wdog    <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        fpu_a   <= req_a[int'(win_idx)*FP_W +: FP_W];
                        fpu_b   <= req_b[int'(win_idx)*FP_W +: FP_W];
                        owner   <= win_idx;
                        rr_last <= win_idx;
                    end
                end
                ST_ISSUE: wdog <= '0;
                ST_WAIT: begin
                    if (done_seen) begin
                        rsp_sum <= fpu_sum;
                        rsp_err <= 1'b0;
                    end else if (wdog_expired) begin
                        rsp_sum <= FP_QNAN;
                        rsp_err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
